// File: rtl/dec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dec_pkg
// Purpose  : Shared state encoding, mode constants and one-hot helper for
//            the dec_n_seq select/strobe generator.
// Revision : 1.0 - initial release
// ============================================================================
package dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

  localparam logic c_MODE_HOLD  = 1'b0;
  localparam logic c_MODE_SWEEP = 1'b1;
  localparam int   c_MAX_N      = 8;

  // Full-width result; callers keep the low 2**N bits.
  function automatic logic [(2**c_MAX_N)-1:0] onehot(input logic [c_MAX_N-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dec_onehot.sv
`default_nettype none
// ============================================================================
// Module   : dec_onehot
// Purpose  : Combinational N-to-2^N one-hot decoder with enable.
// Revision : 1.0 - initial release
// ============================================================================
module dec_onehot
  import dec_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]      i_idx,
  input  logic              i_en,
  output logic [2**N-1:0]   o_y
);

  localparam int c_W = 2**N;

  assign o_y = i_en ? c_W'(onehot(8'(i_idx))) : '0;

endmodule
`default_nettype wire

// File: rtl/dec_n_seq.sv
`default_nettype none
// ============================================================================
// Module   : dec_n_seq
// Purpose  : Registered N-to-2^N one-hot decoder with load/hold/sweep modes.
//            Macro DEC_SWEEP_EN enables the walking-one sweep and wrap pulse.
// Revision : 1.0 - initial release
// ============================================================================
module dec_n_seq
  import dec_pkg::*;
#(
  parameter int N = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic              stop,
  input  logic              mode,
  input  logic              dir,
  input  logic [N-1:0]      a,
  output logic [2**N-1:0]   y,
  output logic [N-1:0]      idx,
  output logic              wrap,
  output logic              busy
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N-1:0]        r_idx;
  logic [N-1:0]        w_idx_nxt;
  logic [2**N-1:0]     r_y;
  logic [2**N-1:0]     w_y_nxt;
  logic                r_wrap;
  logic                w_wrap_nxt;
  logic                r_busy;
  logic                w_dec_en;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_dec_en    = 1'b0;
    w_wrap_nxt  = 1'b0;
    if (stop) begin
      w_state_nxt = ST_IDLE;
    end else if (load) begin
      w_idx_nxt = a;
      w_dec_en  = en;
`ifdef DEC_SWEEP_EN
      w_state_nxt = (mode == c_MODE_SWEEP) ? ST_SWEEP : ST_HOLD;
`else
      w_state_nxt = ST_HOLD;
`endif
    end else begin
      case (r_state)
        ST_HOLD: w_dec_en = en;
`ifdef DEC_SWEEP_EN
        ST_SWEEP: begin
          if (en) begin
            w_dec_en = 1'b1;
            if (dir) begin
              w_idx_nxt  = r_idx - 1'b1;
              w_wrap_nxt = (r_idx == '0);
            end else begin
              w_idx_nxt  = r_idx + 1'b1;
              w_wrap_nxt = (r_idx == '1);
            end
          end
        end
`endif
        default: ;
      endcase
    end
`ifndef DEC_SWEEP_EN
    // mode/dir have no effect in this build; folded into a constant zero.
    w_wrap_nxt = 1'b0 & mode & dir;
`endif
  end

  dec_onehot #(.N(N)) u_dec (
    .i_idx (w_idx_nxt),
    .i_en  (w_dec_en),
    .o_y   (w_y_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_y     <= '0;
      r_wrap  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_y     <= w_y_nxt;
      r_wrap  <= w_wrap_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign y    = r_y;
  assign idx  = r_idx;
  assign wrap = r_wrap;
  assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dec_n_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_n_seq
// Purpose  : Self-checking bench for dec_n_seq at N=3, N=1 and N=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dec_n_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, en = 1'b0, load = 1'b0, stop = 1'b0, mode = 1'b0, dir = 1'b0;
  logic [7:0]   a8 = 8'd0;

  logic [7:0]   y3;  logic [2:0] idx3; logic wrap3, busy3;
  logic [1:0]   y1;  logic       idx1; logic wrap1, busy1;
  logic [255:0] y8;  logic [7:0] idx8; logic wrap8, busy8;

  dec_n_seq #(.N(3)) u_d3 (.clk(clk), .rst(rst), .en(en), .load(load), .stop(stop),
    .mode(mode), .dir(dir), .a(a8[2:0]), .y(y3), .idx(idx3), .wrap(wrap3), .busy(busy3));
  dec_n_seq #(.N(1)) u_d1 (.clk(clk), .rst(rst), .en(en), .load(load), .stop(stop),
    .mode(mode), .dir(dir), .a(a8[0:0]), .y(y1), .idx(idx1), .wrap(wrap1), .busy(busy1));
  dec_n_seq #(.N(8)) u_d8 (.clk(clk), .rst(rst), .en(en), .load(load), .stop(stop),
    .mode(mode), .dir(dir), .a(a8), .y(y8), .idx(idx8), .wrap(wrap8), .busy(busy8));

`ifdef DEC_SWEEP_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0=idle 1=hold 2=sweep, y position (-1 = all zero).
  int WID[3]   = '{3, 1, 8};
  int m_st[3]  = '{0, 0, 0};
  int m_idx[3] = '{0, 0, 0};
  int m_yp[3]  = '{-1, -1, -1};
  int m_wr[3]  = '{0, 0, 0};

  function automatic logic [255:0] dut_y(int k);
    case (k)
      0:       return 256'(y3);
      1:       return 256'(y1);
      default: return y8;
    endcase
  endfunction

  function automatic logic [255:0] dut_idx(int k);
    case (k)
      0:       return 256'(idx3);
      1:       return 256'(idx1);
      default: return 256'(idx8);
    endcase
  endfunction

  function automatic logic [1:0] dut_wb(int k);
    case (k)
      0:       return {wrap3, busy3};
      1:       return {wrap1, busy1};
      default: return {wrap8, busy8};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int p, ak, old;
      p  = 1 << WID[k];
      ak = int'(a8) % p;
      m_wr[k] = 0;
      if (rst) begin
        m_st[k] = 0; m_idx[k] = 0; m_yp[k] = -1;
      end else if (stop) begin
        m_st[k] = 0; m_yp[k] = -1;
      end else if (load) begin
        m_idx[k] = ak;
        m_st[k]  = (SW && mode) ? 2 : 1;
        m_yp[k]  = en ? ak : -1;
      end else if (m_st[k] == 1) begin
        m_yp[k] = en ? m_idx[k] : -1;
      end else if (m_st[k] == 2) begin
        if (en) begin
          old      = m_idx[k];
          m_idx[k] = dir ? (old + p - 1) % p : (old + 1) % p;
          m_wr[k]  = dir ? int'(old == 0) : int'(old == p - 1);
          m_yp[k]  = m_idx[k];
        end else begin
          m_yp[k] = -1;
        end
      end else begin
        m_yp[k] = -1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < 3; k++) begin
      logic [255:0] ey;
      logic [1:0]   wb;
      ey = (m_yp[k] < 0) ? '0 : (256'd1 << m_yp[k]);
      wb = dut_wb(k);
      chk($sformatf("%s.N%0d.y", tag, WID[k]), dut_y(k), ey);
      chk($sformatf("%s.N%0d.idx", tag, WID[k]), dut_idx(k), 256'(m_idx[k]));
      chk($sformatf("%s.N%0d.wrap", tag, WID[k]), 256'(wb[1]), 256'(m_wr[k]));
      chk($sformatf("%s.N%0d.busy", tag, WID[k]), 256'(wb[0]), 256'(m_st[k] != 0));
      chk($sformatf("%s.N%0d.onehot", tag, WID[k]), 256'($countones(dut_y(k)) <= 1), 256'(1));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic rst, en, load, stop, mode, dir;
    logic [2:0] a;
    logic [7:0] ey;
    logic [2:0] eidx;
    logic ewrap, ebusy;
  } vec_t;

  vec_t tv[10];
  int   cnt8[256];
  int   cnt1[2];
  int   nwrap8;

  initial begin
    tv[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 8'h00, 3'd0, 1'b0, 1'b0};
    tv[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 8'h00, 3'd0, 1'b0, 1'b0};
    tv[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 8'h20, 3'd5, 1'b0, 1'b1};
    tv[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h20, 3'd5, 1'b0, 1'b1};
    tv[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 1'b0, 1'b1};
    tv[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 8'h00, 3'd5, 1'b0, 1'b1};
    tv[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h20, 3'd5, 1'b0, 1'b1};
    tv[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 1'b0, 1'b0};
    tv[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 8'h04, 3'd2, 1'b0, 1'b1};
    tv[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      rst = tv[i].rst; en = tv[i].en; load = tv[i].load; stop = tv[i].stop;
      mode = tv[i].mode; dir = tv[i].dir; a8 = {5'd0, tv[i].a};
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.y", i), 256'(y3), 256'(tv[i].ey));
      chk($sformatf("vec%0d.idx", i), 256'(idx3), 256'(tv[i].eidx));
      chk($sformatf("vec%0d.wrap", i), 256'(wrap3), 256'(tv[i].ewrap));
      chk($sformatf("vec%0d.busy", i), 256'(busy3), 256'(tv[i].ebusy));
    end

    // Incrementing sweep from 6: wraps on reaching 0 and once per 8 steps.
    rst = 1'b0; stop = 1'b0; load = 1'b1; mode = 1'b1; dir = 1'b0; en = 1'b1; a8 = 8'd6;
    tick("sw_ld");
    load = 1'b0;
    for (int s = 0; s <= 10; s++) begin
      int ei;
      if (s > 0) tick("sw_inc");
      ei = SW ? (6 + s) % 8 : 6;
      chk($sformatf("sw_inc%0d.y", s), 256'(y3), 256'd1 << ei);
      chk($sformatf("sw_inc%0d.idx", s), 256'(idx3), 256'(ei));
      chk($sformatf("sw_inc%0d.wrap", s), 256'(wrap3), 256'(SW && s > 0 && ei == 0));
    end

    // Decrementing sweep from 1, then direction flip.
    load = 1'b1; dir = 1'b1; a8 = 8'd1;
    tick("dec_ld");
    load = 1'b0;
    chk("dec.idx0", 256'(idx3), 256'd1);
    tick("dec");
    chk("dec.idx1", 256'(idx3), SW ? 256'd0 : 256'd1);
    tick("dec");
    chk("dec.idx2", 256'(idx3), SW ? 256'd7 : 256'd1);
    chk("dec.wrap2", 256'(wrap3), 256'(SW));
    dir = 1'b0;
    tick("flip");
    chk("flip.idx", 256'(idx3), SW ? 256'd0 : 256'd1);
    en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick("en_lo");
      chk("en_lo.y", 256'(y3), 256'd0);
      chk("en_lo.wrap", 256'(wrap3), 256'd0);
      chk("en_lo.idx", 256'(idx3), SW ? 256'd0 : 256'd1);
    end
    en = 1'b1;
    tick("en_hi");

    // Restart into HOLD, stop, then reset mid-sweep.
    load = 1'b1; mode = 1'b0; a8 = 8'd2;
    tick("restart");
    load = 1'b0;
    chk("restart.y", 256'(y3), 256'h04);
    chk("restart.wrap", 256'(wrap3), 256'd0);
    stop = 1'b1;
    tick("stop");
    stop = 1'b0;
    chk("stop.y", 256'(y3), 256'd0);
    chk("stop.busy", 256'(busy3), 256'd0);
    chk("stop.idx", 256'(idx3), 256'd2);
    load = 1'b1; mode = 1'b1; a8 = 8'd7;
    tick("sw2_ld");
    load = 1'b0;
    tick("sw2");
    rst = 1'b1;
    tick("rst_mid");
    rst = 1'b0;
    chk("rst_mid.y", 256'(y3), 256'd0);
    chk("rst_mid.busy", 256'(busy3), 256'd0);
    tick("post_rst");
    tick("post_rst");
    chk("post_rst.y", 256'(y3), 256'd0);
    chk("post_rst.y8", y8, 256'd0);

    // Full period at N=1 and N=8 from address 0.
    for (int b = 0; b < 256; b++) cnt8[b] = 0;
    cnt1[0] = 0; cnt1[1] = 0; nwrap8 = 0;
    load = 1'b1; mode = 1'b1; dir = 1'b0; en = 1'b1; a8 = 8'd0;
    tick("per_ld");
    load = 1'b0;
    for (int c = 1; c <= 256; c++) begin
      tick("period");
      for (int b = 0; b < 256; b++) if (y8[b]) cnt8[b]++;
      if (c <= 2) begin
        if (y1[0]) cnt1[0]++;
        if (y1[1]) cnt1[1]++;
      end
      if (wrap8) nwrap8++;
    end
    for (int b = 0; b < 256; b++)
      chk($sformatf("per8.bit%0d", b), 256'(cnt8[b]), SW ? 256'd1 : (b == 0 ? 256'd256 : 256'd0));
    chk("per1.bit0", 256'(cnt1[0]), SW ? 256'd1 : 256'd2);
    chk("per1.bit1", 256'(cnt1[1]), SW ? 256'd1 : 256'd0);
    chk("per8.wraps", 256'(nwrap8), 256'(SW));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom % 64) == 0;
      stop = ($urandom % 16) == 0;
      load = ($urandom % 8) == 0;
      en   = ($urandom % 4) != 0;
      mode = 1'($urandom);
      dir  = 1'($urandom);
      a8   = 8'($urandom);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
